// File: rtl/convert_fp_if.sv
// Stream bundle for the linear-to-floating-point converter: magnitude in, exponent/significand out.
interface convert_fp_if;
    logic        in_valid;
    logic [10:0] magnitude;
    logic        out_valid;
    logic [2:0]  exponent;
    logic [3:0]  significand;
    logic        fifth_bit;

    modport master (
        output in_valid, magnitude,
        input  out_valid, exponent, significand, fifth_bit
    );

    modport slave (
        input  in_valid, magnitude,
        output out_valid, exponent, significand, fifth_bit
    );
endinterface

// File: rtl/convert_fp.sv
// Converts an 11-bit magnitude to a 3-bit exponent / 4-bit significand with a 1-cycle latency.
// Define CONVERT_FP_ROUND_EN to round the registered result using the first discarded bit.
module convert_fp (
    input  logic         clk,
    input  logic         rst_n,
    convert_fp_if.slave  bus
);

    logic       valid_q, valid_d;
    logic [2:0] exp_q, exp_d;
    logic [3:0] sig_q, sig_d;
    logic       fifth_q, fifth_d;

    logic [2:0]  exp_raw;
    logic [11:0] shifted;
    logic [3:0]  sig_raw;
    logic        fifth_raw;

    // Priority encoder over bits 10..4; the highest set bit wins.
    always_comb begin
        exp_raw = 3'd0;
        for (int i = 4; i <= 10; i++) begin
            if (bus.magnitude[i]) begin
                exp_raw = 3'(i - 3);
            end
        end
    end

    // Appending a zero makes the discarded bit read as 0 when nothing is shifted out.
    assign shifted   = {bus.magnitude, 1'b0} >> exp_raw;
    assign sig_raw   = shifted[4:1];
    assign fifth_raw = shifted[0];

    always_comb begin
        valid_d = bus.in_valid;
        exp_d   = exp_q;
        sig_d   = sig_q;
        fifth_d = fifth_q;
        if (bus.in_valid) begin
            exp_d   = exp_raw;
            sig_d   = sig_raw;
            fifth_d = fifth_raw;
`ifdef CONVERT_FP_ROUND_EN
            if (fifth_raw) begin
                if (sig_raw != 4'd15) begin
                    sig_d = sig_raw + 4'd1;
                end else if (exp_raw != 3'd7) begin
                    sig_d = 4'd8;
                    exp_d = exp_raw + 3'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            exp_q   <= 3'd0;
            sig_q   <= 4'd0;
            fifth_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            fifth_q <= fifth_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.exponent    = exp_q;
    assign bus.significand = sig_q;
    assign bus.fifth_bit   = fifth_q;

endmodule

// File: tb/tb_convert_fp.sv
// Directed bench for convert_fp: reset, single conversions, boundaries and a streaming burst.
module tb_convert_fp;

    logic clk;
    logic rst_n;
    int   errs;
    int   n_chk;

    convert_fp_if bus ();

    convert_fp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs != expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input int v, input int e, input int s,
                             input int f);
        check({tag, ".valid"}, int'(bus.out_valid), v);
        check({tag, ".exp"}, int'(bus.exponent), e);
        check({tag, ".sig"}, int'(bus.significand), s);
        check({tag, ".fifth"}, int'(bus.fifth_bit), f);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge after capture.
    task automatic one_shot(input string tag, input int mag, input int e, input int s,
                            input int f);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.magnitude = 11'(mag);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        check_out(tag, 1, e, s, f);
    endtask

    int st_mag [4] = '{16, 1024, 422, 3};
    int st_e   [4] = '{1, 7, 5, 0};
    int st_s   [4] = '{8, 8, 13, 3};

    initial begin
        errs          = 0;
        n_chk         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.magnitude = 11'd0;
        repeat (2) @(negedge clk);
        check_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        one_shot("m422", 422, 5, 13, 0);
        one_shot("m0", 0, 0, 0, 0);
        one_shot("m7", 7, 0, 7, 0);
        one_shot("m15", 15, 0, 15, 0);
        one_shot("m16", 16, 1, 8, 0);
`ifdef CONVERT_FP_ROUND_EN
        one_shot("m2047", 2047, 7, 15, 1);
        one_shot("m62", 62, 3, 8, 1);
        one_shot("m25", 25, 1, 13, 1);
`else
        one_shot("m2047", 2047, 7, 15, 1);
        one_shot("m62", 62, 2, 15, 1);
        one_shot("m25", 25, 1, 12, 1);
`endif
        @(negedge clk);
`ifdef CONVERT_FP_ROUND_EN
        check_out("hold", 0, 1, 13, 1);
`else
        check_out("hold", 0, 1, 12, 1);
`endif

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) check_out($sformatf("stream%0d", i - 1), 1, st_e[i-1], st_s[i-1], 0);
            bus.in_valid  = 1'b1;
            bus.magnitude = 11'(st_mag[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_out("stream3", 1, st_e[3], st_s[3], 0);
        @(negedge clk);
        check_out("stream_idle", 0, 0, 3, 0);

        // Asynchronous reset while a result is being presented.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.magnitude = 11'd2047;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_out("pre_rst", 1, 7, 15, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_out("post_rst", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule

// File: doc/convert_fp.md
Name: convert_fp

Overview:
- Converts an 11-bit unsigned magnitude into a compact floating-point form: value ≈ significand × 2^exponent.
- Outputs are a 3-bit exponent, a 4-bit significand and the first discarded bit (fifth_bit) for downstream rounding.
- Sits in the linear-to-floating-point conversion path after the sign/magnitude stage.
- Registered outputs with a simple valid qualifier.

Parameters:
- None. Widths are fixed: magnitude 11, exponent 3, significand 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  magnitude is valid this cycle.
- magnitude  input  11  unsigned input value, 0..2047.
- out_valid  output  1  outputs hold a new result.
- exponent  output  3  shift count, 0..7.
- significand  output  4  four bits starting at the leading one.
- fifth_bit  output  1  bit immediately below the significand.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, exponent=0, significand=0, fifth_bit=0. Reset mid-operation discards any pending result.
- Latency: exactly 1 cycle.
  - When in_valid=1 at rising edge N, the result appears after edge N and out_valid=1 for one cycle.
  - When in_valid=0, out_valid=0 and the data outputs hold their last values.
  - Back-to-back inputs give back-to-back results. There is no backpressure.
- Let p = index of the most significant 1 in magnitude (bit 10 .. bit 0).
  - p >= 4: exponent = p-3; significand = magnitude[p:p-3]; fifth_bit = magnitude[p-4].
  - p <= 3 or magnitude = 0: exponent = 0; significand = magnitude[3:0]; fifth_bit = 0.
- Range of the exponent:
  - Maximum is 7, reached for p = 10, i.e. magnitude >= 1024.
  - Minimum nonzero exponent is 1, at p = 4.
- Truncation: significand × 2^exponent <= magnitude, and the error is < 2^exponent.
- Leading-one detection is a priority encoder over bits 10..4. Purely combinational ahead of the output registers, with no multi-cycle paths.
- With rounding disabled (default), fifth_bit is informational only.

Optional Feature:
- Macro: CONVERT_FP_ROUND_EN.
- Defined: the registered significand and exponent are rounded using fifth_bit.
  - fifth_bit=1 and significand<15: significand+1.
  - fifth_bit=1, significand=15, exponent<7: significand=8, exponent+1.
  - fifth_bit=1, significand=15, exponent=7: saturate at significand=15, exponent=7.
  - fifth_bit output still reports the pre-rounding discarded bit.
  - Latency remains 1 cycle.
- Undefined: pure truncation as described in Behaviour.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with results pending -> all outputs 0 immediately, out_valid=0 until the next in_valid.
- magnitude=422 (00110100110), in_valid pulse -> next cycle exponent=5, significand=13, fifth_bit=0, out_valid=1; 13×2^5=416.
- Small values 0, 7, 15 -> exponent=0, significand=0/7/15, fifth_bit=0. Boundary value 16 -> exponent=1, significand=8, fifth_bit=0.
- magnitude=2047 -> exponent=7, significand=15, fifth_bit=1. With CONVERT_FP_ROUND_EN -> saturates at exponent=7, significand=15.
- magnitude=62 (0000_0111110) -> exponent=2, significand=15, fifth_bit=1. With CONVERT_FP_ROUND_EN -> exponent=3, significand=8. Also magnitude=25 -> exponent=1, significand=12, fifth_bit=1; rounded gives significand=13.
- Streaming: in_valid high for 4 consecutive cycles with 16, 1024, 422, 3 -> four consecutive out_valid cycles giving (1,8,0), (7,8,0), (5,13,0), (0,3,0); then in_valid=0 -> out_valid=0 and outputs hold (0,3,0).
